uart_rx_os: RTL

UART_RX_OS -- requirements
Module: uart_rx_os

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_sync.sv | 26 ++
 rtl/uart_rx_os.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial input.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic srst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_os.sv
// 8N1 UART receiver: samples mid-bit using a BAUD_RATE-cycle bit counter,
// presents bytes on a valid/ready port and flags framing errors and overruns.
//
// state        | meaning
// ST_IDLE      | line idle, waiting for rx_s low
// ST_START     | half-bit wait, then confirm start bit
// ST_DATA      | sampling 8 data bits LSB first
// ST_STOP      | sampling stop bit, then one cycle to deliver the result
// ST_WAIT_IDLE | framing error seen, waiting for line to return high
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int BAUD_RATE = 24
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = $clog2(BAUD_RATE);
    localparam logic [CW-1:0] CNT_LAST  = CW'(BAUD_RATE - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_RATE / 2 - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

    logic rx_s;

    uart_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk  (clk),
        .srst (srst),
        .d    (rx),
        .q    (rx_s)
    );

    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 stop_hit_q, stop_hit_d;
    logic                 stop_bit_q, stop_bit_d;
    logic [7:0]           data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 load;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        stop_hit_d = stop_hit_q;
        stop_bit_d = stop_bit_q;
        data_d     = data_q;
        valid_d    = valid_q;
        ferr_d     = 1'b0;
        ovr_d      = ovr_q;
        load       = 1'b0;

        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                // Stop bit is latched at its sample edge and acted on one cycle later.
                if (stop_hit_q) begin
                    stop_hit_d = 1'b0;
                    cnt_d      = '0;
                    if (stop_bit_q) begin
                        load    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_IDLE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    stop_hit_d = 1'b1;
                    stop_bit_d = rx_s;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new byte always wins; a pending unconsumed byte is an overrun.
        if (load) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            if (valid_q && !ready) begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            stop_hit_q <= 1'b0;
            stop_bit_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            stop_hit_q <= stop_hit_d;
            stop_bit_q <= stop_bit_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign data_out  = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
